// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel; master drives vld/dat, slave drives rdy.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             vld;
  logic             rdy;
  logic [WIDTH-1:0] dat;

  modport master (output vld, output dat, input  rdy);
  modport slave  (input  vld, input  dat, output rdy);
endinterface

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline stage: main register M drives the output, skid register S absorbs one beat.
// Latency one falling edge; in/out handshakes decode registered state only, so no ready/valid comb path.
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  pipe_stage_reg_if.slave       in_if,
  pipe_stage_reg_if.master      out_if,
  input  logic                  flush_i,
  input  logic                  stat_clr_i,
  output logic [CNT_W-1:0]      stall_count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_rdy, out_vld;
  logic             in_fire, out_fire;

  assign in_fire  = in_if.vld & in_rdy;
  assign out_fire = out_vld & out_if.rdy;

  // State register: updates on the falling edge to line up with the datapath pipeline.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_ONE;
      ST_ONE: begin
        if (in_fire && !out_fire)      state_d = ST_FULL;
        else if (!in_fire && out_fire) state_d = ST_EMPTY;
      end
      ST_FULL:  if (out_fire) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_comb begin
    out_vld = (state_q != ST_EMPTY);
    in_rdy  = (state_q != ST_FULL);
  end

  // Flush only retires the state; M/S keep their contents and nothing is captured.
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (!flush_i) begin
      case (state_q)
        ST_EMPTY: if (in_fire) m_d = in_if.dat;
        ST_ONE: begin
          if (in_fire && out_fire) m_d = in_if.dat;
          else if (in_fire)        s_d = in_if.dat;
        end
        ST_FULL:  if (out_fire) m_d = s_q;
        default:  m_d = m_q;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr_i) begin
      cnt_d = '0;
    end else if (out_vld && !out_if.rdy && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_if.rdy     = in_rdy;
  assign out_if.vld    = out_vld;
  assign out_if.dat    = m_q;
  assign stall_count_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue-based model.
module tb_pipe_stage_reg;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          flush    = 1'b0;
  logic          stat_clr = 1'b0;
  logic [CW-1:0] stall_count;

  pipe_stage_reg_if #(.WIDTH(W)) in_if ();
  pipe_stage_reg_if #(.WIDTH(W)) out_if ();

  pipe_stage_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_if        (in_if),
    .out_if       (out_if),
    .flush_i      (flush),
    .stat_clr_i   (stat_clr),
    .stall_count_o(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the stage is a FIFO of at most two payloads; OutData shows the head,
  // or the last head seen when empty.
  logic [W-1:0] mq[$];
  logic [W-1:0] mhold;
  int           mcnt;

  task automatic model_reset();
    mq.delete();
    mhold = '0;
    mcnt  = 0;
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic sc);
    bit acc, snd, stall;
    in_if.vld  = iv;
    in_if.dat  = id;
    out_if.rdy = ordy;
    flush      = fl;
    stat_clr   = sc;
    @(negedge clk);
    acc   = iv && (mq.size() < 2);
    snd   = (mq.size() > 0) && ordy;
    stall = (mq.size() > 0) && !ordy;
    if (sc) mcnt = 0;
    else if (stall && mcnt < (1 << CW) - 1) mcnt++;
    if (fl) begin
      mq.delete();
    end else begin
      if (snd) void'(mq.pop_front());
      if (acc) mq.push_back(id);
      if (mq.size() > 0) mhold = mq[0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_if.vld = 1'b0; in_if.dat = '0; out_if.rdy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0h want 0", out_if.vld); end
    checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0h want 1", in_if.rdy); end
    checks++; if (out_if.dat !== 32'h0) begin errors++; $display("FAIL reset_dat got %0h want 0", out_if.dat); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_count); end
    model_reset();
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    #1;
    @(posedge clk); #1;
    checks++; if (out_if.vld !== 1'b0 || in_if.rdy !== 1'b1) begin errors++; $display("FAIL reset_release got vld=%0h rdy=%0h want 0/1", out_if.vld, in_if.rdy); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.vld !== 1'b1) begin errors++; $display("FAIL single_vld got %0h want 1", out_if.vld); end
    checks++; if (out_if.dat !== 32'hA5A5_0001) begin errors++; $display("FAIL single_dat got %0h want a5a50001", out_if.dat); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL single_drain got %0h want 0", out_if.vld); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      checks++; if (out_if.vld !== 1'b1 || out_if.dat !== W'(i)) begin errors++; $display("FAIL stream_dat got %0h/%0h want 1/%0h", out_if.vld, out_if.dat, i); end
      checks++; if (in_if.rdy !== 1'b1) begin errors++; $display("FAIL stream_rdy got %0h want 1", in_if.rdy); end
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL stream_end got %0h want 0", out_if.vld); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    checks++; if (out_if.dat !== 32'h10 || in_if.rdy !== 1'b1) begin errors++; $display("FAIL bp_first got %0h/%0h want 10/1", out_if.dat, in_if.rdy); end
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    checks++; if (in_if.rdy !== 1'b0 || out_if.dat !== 32'h10 || out_if.vld !== 1'b1) begin errors++; $display("FAIL bp_full got rdy=%0h dat=%0h want 0/10", in_if.rdy, out_if.dat); end
    drive(1'b1, 32'h12, 1'b0, 1'b0, 1'b0);
    checks++; if (in_if.rdy !== 1'b0 || out_if.dat !== 32'h10) begin errors++; $display("FAIL bp_hold got rdy=%0h dat=%0h want 0/10", in_if.rdy, out_if.dat); end
    drive(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.dat !== 32'h11 || in_if.rdy !== 1'b1) begin errors++; $display("FAIL bp_drain1 got %0h/%0h want 11/1", out_if.dat, in_if.rdy); end
    drive(1'b1, 32'h12, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.dat !== 32'h12 || out_if.vld !== 1'b1) begin errors++; $display("FAIL bp_drain2 got %0h want 12", out_if.dat); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL bp_empty got %0h want 0", out_if.vld); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
    checks++; if (out_if.vld !== 1'b0 || in_if.rdy !== 1'b1) begin errors++; $display("FAIL flush_state got vld=%0h rdy=%0h want 0/1", out_if.vld, in_if.rdy); end
    checks++; if (out_if.dat !== 32'h20) begin errors++; $display("FAIL flush_m_kept got %0h want 20", out_if.dat); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checks++; if (out_if.vld !== 1'b0 || out_if.dat !== 32'h20) begin errors++; $display("FAIL flush_after got %0h/%0h want 0/20", out_if.vld, out_if.dat); end
    end
  endtask

  task automatic test_stall_sat();
    drive(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL sat_clr0 got %0d want 0", stall_count); end
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++; if (stall_count !== CW'((k > 15) ? 15 : k)) begin errors++; $display("FAIL sat_count got %0d want %0d", stall_count, (k > 15) ? 15 : k); end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL sat_clr_stall got %0d want 0", stall_count); end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL sat_restart got %0d want 1", stall_count); end
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL sat_flush_cnt got %0d want 2", stall_count); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
    checks++; if (stall_count !== 4'd0 || out_if.vld !== 1'b0) begin errors++; $display("FAIL sat_clr_idle got %0d/%0h want 0/0", stall_count, out_if.vld); end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 32'h60, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h61, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_if.vld !== 1'b0 || in_if.rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_hs got vld=%0h rdy=%0h want 0/1", out_if.vld, in_if.rdy); end
    checks++; if (out_if.dat !== 32'h0 || stall_count !== 4'd0) begin errors++; $display("FAIL mid_rst_dat got %0h/%0d want 0/0", out_if.dat, stall_count); end
    model_reset();
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    #1;
    drive(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.vld !== 1'b1 || out_if.dat !== 32'h77) begin errors++; $display("FAIL mid_rst_accept got %0h/%0h want 1/77", out_if.vld, out_if.dat); end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (out_if.vld !== 1'b0) begin errors++; $display("FAIL mid_rst_drain got %0h want 0", out_if.vld); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
            ($urandom % 20) == 0, ($urandom % 25) == 0);
      checks++; if (out_if.vld !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_vld cyc %0d got %0h want %0h", n, out_if.vld, mq.size() > 0); end
      checks++; if (in_if.rdy !== (mq.size() < 2)) begin errors++; $display("FAIL rnd_rdy cyc %0d got %0h want %0h", n, in_if.rdy, mq.size() < 2); end
      checks++; if (out_if.dat !== mhold) begin errors++; $display("FAIL rnd_dat cyc %0d got %0h want %0h", n, out_if.dat, mhold); end
      checks++; if (stall_count !== CW'(mcnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", n, stall_count, mcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall_sat();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits; legal range 1..256.
REQ-002 Parameter CNT_W, default 16: stall-counter width; legal range 4..32.
REQ-003 Clk  in  1: single clock; all state updates on the falling edge, consistent with the datapath pipeline registers.
REQ-004 Rst_n  in  1: asynchronous, active-low reset.
REQ-005 InValid  in  1: upstream payload valid.
REQ-006 InReady  out  1: stage can accept payload.
REQ-007 InData  in  WIDTH: upstream payload.
REQ-008 OutValid  out  1: OutData valid.
REQ-009 OutReady  in  1: downstream accepts payload.
REQ-010 OutData  out  WIDTH: downstream payload.
REQ-011 Flush  in  1: synchronous squash of all held entries.
REQ-012 StatClr  in  1: synchronous clear of StallCount.
REQ-013 StallCount  out  CNT_W: saturating count of backpressure cycles.

Function
REQ-014 Storage: main register M (drives OutData) plus one skid register S; state EMPTY, ONE (M valid) or FULL (M and S valid).
REQ-015 Definitions: in_fire = InValid & InReady; out_fire = OutValid & OutReady, both sampled at the falling edge.
REQ-016 OutValid = (state != EMPTY); InReady = (state != FULL); both decode only registered state, with no combinational path from any input.
REQ-017 EMPTY: in_fire -> M <= InData, go to ONE; otherwise stay.
REQ-018 ONE: in_fire & out_fire -> M <= InData, stay ONE; in_fire & !out_fire -> S <= InData, go to FULL; !in_fire & out_fire -> EMPTY; neither -> stay.
REQ-019 FULL: out_fire -> M <= S, go to ONE; otherwise hold; no input is accepted.
REQ-020 Latency: a payload accepted at edge N appears on OutData with OutValid=1 after edge N, when the stage was EMPTY or M was consumed at edge N.
REQ-021 Throughput: one payload per cycle while OutReady=1; the order of payloads is preserved, with none dropped or duplicated.
REQ-022 Flush has highest priority: at that edge the state goes to EMPTY, InData is not captured even if in_fire, out_fire is still counted by downstream as a transfer, and M/S contents are left unchanged.
REQ-023 StallCount increments by 1 at each edge where OutValid=1 & OutReady=0, and saturates at 2^CNT_W-1 without wrap.
REQ-024 StatClr forces StallCount to 0 at that edge and overrides a coincident increment; Flush does not affect StallCount.
REQ-025 OutData is stable whenever OutValid=1 & OutReady=0.

Reset
REQ-026 Rst_n=0 immediately, without waiting for a clock edge, forces: state EMPTY, OutValid=0, InReady=1, M=0, S=0, OutData=0, StallCount=0.
REQ-027 Reset asserted mid-transfer discards M and S; the first acceptance after release is at the first falling edge with Rst_n=1 and InValid=1.
REQ-028 Rst_n is deasserted synchronously to the rising edge of Clk by the external reset synchroniser; no state changes on the deassertion itself.

Verification
REQ-029 Reset, then InValid=1, InData=0xA5A5_0001, OutReady=1 for one cycle -> after the edge OutValid=1, OutData=0xA5A5_0001; one cycle later OutValid=0.
REQ-030 Stream 0x1..0x8 with OutReady=1 every cycle -> OutData sequence 0x1..0x8 on consecutive cycles; InReady stays 1 throughout.
REQ-031 OutReady=0; send 0x10 then 0x11 -> state FULL, InReady=0, OutData=0x10 held. Then OutReady=1 -> 0x10 transfers, then 0x11; 0x12, offered while InReady=0, is accepted only after 0x10 drains.
REQ-032 FULL state, Flush=1 with InValid=1, InData=0x99 -> next cycle OutValid=0, InReady=1, and 0x99 never appears on OutData.
REQ-033 CNT_W=4, OutValid=1, OutReady=0 for 20 cycles -> StallCount reads 15 and holds. StatClr=1 for one cycle -> StallCount=0. StatClr with a stall in the same cycle -> StallCount=0.
REQ-034 Assert Rst_n=0 between edges while FULL -> OutValid=0, InReady=1, OutData=0 immediately; after release, 0x77 is accepted normally.
